// File: rtl/filtro_pb_pkg.sv
// -----------------------------------------------------------------------------
// filtro_pb_pkg
// Shared definitions for the low-pass bit filter controller:
//   - state_t        : controller states (FILL / IDLE / EVAL)
//   - SETTLE_W       : width of the settle counter (SETTLE up to 16)
//   - count_width()  : width of a ones-count over an N-bit window
//   - default_thresh(): default decision threshold (half the window)
// -----------------------------------------------------------------------------
package filtro_pb_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        IDLE = 2'd1,
        EVAL = 2'd2
    } state_t;

    localparam int SETTLE_W = 5;

    // A count over n bits must also represent n itself (all ones).
    function automatic int count_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int default_thresh(input int n);
        return n / 2;
    endfunction

endpackage

// File: rtl/filtro_pb_shift.sv
// -----------------------------------------------------------------------------
// filtro_pb_shift
// Oversampled-bit window shift register plus the frozen snapshot handed to the
// external filter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bit_in      : serial input bit
//   bit_valid   : shift enable (one bit accepted per cycle)
//   load        : capture the post-shift window into snapshot this cycle
//   snapshot    : frozen window, bit 0 is the newest bit
// -----------------------------------------------------------------------------
module filtro_pb_shift
    import filtro_pb_pkg::*;
#(
    parameter int N = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         load,
    output logic [N-1:0] snapshot
);

    logic [N-1:0] window;
    logic [N-1:0] window_next;

    // The snapshot must include the bit accepted on the loading cycle, so it
    // is taken from the shifted value rather than the registered window.
    assign window_next = {window[N-2:0], bit_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window   <= '0;
            snapshot <= '0;
        end else begin
            if (bit_valid) begin
                window <= window_next;
            end
            if (load) begin
                snapshot <= window_next;
            end
        end
    end

endmodule

// File: rtl/filtro_pb_ctrl.sv
// -----------------------------------------------------------------------------
// filtro_pb_ctrl
// Controller around an external ones-counting filter (FiltroPB). Collects a
// window of SAMPLES*OSF oversampled bits, and every OSF accepted bits freezes
// the window, enables the filter for SETTLE cycles, then latches the returned
// count and a majority decision.
// Ports:
//   Clk, Reset_n  : clock, asynchronous active-low reset
//   BitIn         : serial oversampled input bit
//   BitValid      : BitIn qualifier
//   Clear         : synchronous restart of the fill, clears Overrun
//   FilterData    : frozen window to the filter (bit 0 newest)
//   FilterEnable  : filter enable, high during evaluation only
//   FilterCount   : ones count returned by the filter
//   FiltBit       : decided output bit (count > THRESH)
//   FiltCount     : count behind FiltBit
//   OutValid      : one-cycle strobe, FiltBit/FiltCount updated
//   Overrun       : sticky, a decimation trigger was dropped
// -----------------------------------------------------------------------------
module filtro_pb_ctrl
    import filtro_pb_pkg::*;
#(
    parameter int SAMPLES = 128,
    parameter int OSF     = 8,
    parameter int SETTLE  = 2,
    parameter int THRESH  = default_thresh(SAMPLES * OSF)
) (
    input  logic                                  Clk,
    input  logic                                  Reset_n,
    input  logic                                  BitIn,
    input  logic                                  BitValid,
    input  logic                                  Clear,
    output logic [SAMPLES*OSF-1:0]                FilterData,
    output logic                                  FilterEnable,
    input  logic [count_width(SAMPLES*OSF)-1:0]   FilterCount,
    output logic                                  FiltBit,
    output logic [count_width(SAMPLES*OSF)-1:0]   FiltCount,
    output logic                                  OutValid,
    output logic                                  Overrun
);

    localparam int N  = SAMPLES * OSF;
    localparam int CW = count_width(N);

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         bit_cnt;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic                  fill_done;
    logic                  phase_wrap;
    logic                  eval_last;
    logic                  load_snap;
    logic                  capture;
    logic                  overrun_set;

    function automatic logic decide(input logic [CW-1:0] count);
        return count > CW'(THRESH);
    endfunction

    filtro_pb_shift #(
        .N (N)
    ) u_shift (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .bit_in    (BitIn),
        .bit_valid (BitValid),
        .load      (load_snap),
        .snapshot  (FilterData)
    );

    // bit_cnt counts the fill while in FILL, then doubles as the decimation
    // phase counter; it wraps in EVAL too, so a dropped trigger keeps phase.
    assign fill_done  = BitValid && (state == FILL) && (bit_cnt == CW'(N - 1));
    assign phase_wrap = BitValid && (state != FILL) && (bit_cnt == CW'(OSF - 1));
    assign eval_last  = (state == EVAL) && (settle_cnt == SETTLE_W'(1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        load_snap    = 1'b0;
        capture      = 1'b0;
        overrun_set  = 1'b0;
        FilterEnable = 1'b0;
        case (state)
            FILL: begin
                if (fill_done) begin
                    load_snap  = 1'b1;
                    state_next = EVAL;
                end
            end
            IDLE: begin
                if (phase_wrap) begin
                    load_snap  = 1'b1;
                    state_next = EVAL;
                end
            end
            EVAL: begin
                FilterEnable = 1'b1;
                if (eval_last) begin
                    capture = 1'b1;
                    if (phase_wrap) begin
                        load_snap  = 1'b1;
                        state_next = EVAL;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (phase_wrap) begin
                    // Filter busy on a stale snapshot: drop this trigger.
                    overrun_set = 1'b1;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
        // Clear takes priority over any trigger or pending result.
        if (Clear) begin
            state_next  = FILL;
            load_snap   = 1'b0;
            capture     = 1'b0;
            overrun_set = 1'b0;
        end
    end

    // Stage boundary: counters and result registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bit_cnt    <= '0;
            settle_cnt <= '0;
            Overrun    <= 1'b0;
            OutValid   <= 1'b0;
            FiltBit    <= 1'b0;
            FiltCount  <= '0;
        end else begin
            OutValid <= capture;
            if (capture) begin
                FiltCount <= FilterCount;
                FiltBit   <= decide(FilterCount);
            end

            if (Clear) begin
                Overrun <= 1'b0;
            end else if (overrun_set) begin
                Overrun <= 1'b1;
            end

            if (Clear) begin
                bit_cnt <= '0;
            end else if (BitValid) begin
                if (fill_done || phase_wrap) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end

            if (load_snap) begin
                settle_cnt <= SETTLE_W'(SETTLE);
            end else if ((state == EVAL) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SETTLE_W'(1);
            end
        end
    end

endmodule
